kf8253_bus_sequencer: RTL and testbench
=======================================

Name: kf8253_bus_sequencer

Overview:
- Host-side controller that programs and reads back the KF8253 PIT through its native 8-bit bus (chip_select_n, read_enable_n, write_enable_n, address).
- Accepts one request at a time over a valid/ready handshake and sequences the byte cycles: control word, then LSB and/or MSB.
- Returns a response with read data.
- Sits between the XT chipset register decode / BIOS-init logic and the KF8253 instance; it is the only bus master for the PIT.

Parameters:
- STROBE_CYCLES, 2, clocks that read_enable_n/write_enable_n are held low per byte cycle (range 1..15).
- GAP_CYCLES, 1, idle clocks after each byte cycle with chip_select_n high (range 0..15).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer idle; a request is accepted on a posedge where req_valid & req_ready.
- req_op  in  1  0 = PROGRAM, 1 = READ.
- req_counter  in  2  target counter 0..2; 3 is illegal.
- req_rw  in  2  RW field: 00 latch, 01 LSB, 10 MSB, 11 LSB then MSB.
- req_mode  in  3  counter mode (PROGRAM only).
- req_bcd  in  1  BCD flag (PROGRAM only).
- req_count  in  16  reload value (PROGRAM only).
- rsp_valid  out  1  one-clock completion pulse.
- rsp_data  out  16  read result; 0 for PROGRAM.
- rsp_error  out  1  qualified by rsp_valid; request rejected.
- pit_chip_select_n  out  1  to KF8253.
- pit_read_enable_n  out  1  to KF8253.
- pit_write_enable_n  out  1  to KF8253.
- pit_address  out  2  to KF8253.
- pit_data_out  out  8  to KF8253 data_bus_in.
- pit_data_in  in  8  from KF8253 read data.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_error=0, pit_chip_select_n=1, pit_read_enable_n=1, pit_write_enable_n=1, pit_address=0, pit_data_out=0.
- Reset mid-operation aborts the sequence immediately. Strobes go high asynchronously and no partial response is issued.
- All request fields are captured at acceptance. Later input changes are ignored.
- Byte cycle, one per byte:
  - SETUP (1 clk): cs_n=0, address and data valid, strobes high.
  - STROBE (STROBE_CYCLES clks): the selected strobe is low.
  - HOLD (1 clk): strobe high, cs_n=0, address and data unchanged.
  - GAP (GAP_CYCLES clks): cs_n=1.
  - Read data is sampled from pit_data_in on the last STROBE clock.
  - The write completes on the rising edge of write_enable_n, which is why HOLD keeps cs_n and address stable.
- Main FSM states: IDLE, CTRL, LSB, MSB, RESP.
  - PROGRAM: CTRL writes {counter, rw, mode, bcd} to address 3. Then LSB (req_count[7:0], if rw[0]), then MSB (req_count[15:8], if rw[1]), both to address = counter. rw=00 issues only the latch control word.
  - READ: CTRL writes the latch command {counter, 00, 000, 0}, then reads LSB if rw[0] and MSB if rw[1]. Missing bytes read as 0 in rsp_data. READ with rw=00 is treated as 11.
- RESP: rsp_valid high for one clock. req_ready returns to 1 in the same clock, so back-to-back acceptance is possible on the next edge.
- Latency: N byte cycles give rsp_valid N*(STROBE_CYCLES+2+GAP_CYCLES)+1 clocks after the accept edge. Defaults: PROGRAM rw=11 → 16, READ rw=11 → 16.
- Illegal request (req_counter==3): no bus activity. RESP is entered on the next clock with rsp_error=1 and rsp_data=0.
- Only one strobe is ever low at a time. cs_n is never low outside SETUP/STROBE/HOLD.

Optional Feature:
- Macro KF8253_SEQ_LATCH_EN.
- Defined: READ issues the counter-latch control word before the data reads, as described above.
- Undefined: READ skips CTRL and reads directly. Read latency drops by one byte cycle (default rw=11 → 11 clocks).
- PROGRAM is unaffected either way.

Decomposition:
- Shared package kf8253_seq_pkg holds:
  - typedef op_t: OP_PROGRAM / OP_READ.
  - typedef seq_state_t for the main FSM.
  - typedef cyc_state_t: SETUP / STROBE / HOLD / GAP.
  - constant ADDR_CONTROL = 2'b11.
  - constant LATCH_RW = 2'b00.
- Sub-module kf8253_bus_cycle:
  - Inputs: start, is_read, addr, wdata.
  - Outputs: done pulse, rdata, pin drivers.
  - The main FSM only decides the byte sequence.

Test Plan:
- PROGRAM counter0, mode 3, rw=11, count 16'h1234 → three byte cycles:
  - control write, addr 3, data 8'h36;
  - addr 0, data 8'h34;
  - addr 0, data 8'h12.
  - Each has write_enable_n low exactly 2 clks. rsp_valid 16 clks after accept, rsp_error=0.
- READ counter2, rw=11, model returns 8'hCD then 8'hAB → latch write 8'h80 to addr 3, then reads at addr 2. rsp_data=16'hABCD, latency 16 (11 with KF8253_SEQ_LATCH_EN undefined).
- req_counter=3 → no strobe or cs_n activity. rsp_valid with rsp_error=1 one clock after accept.
- PROGRAM rw=01 count 16'hBEEF → only data 8'hEF written to the target address. rsp_valid at 11 clks.
- Assert reset during the STROBE of the MSB cycle → all pit strobes and cs_n high immediately. No rsp_valid. req_ready=1 after release.
- Two requests presented back-to-back → the second is accepted the clock after the first rsp_valid. GAP_CYCLES separation is preserved between bus cycles.

Source files
------------

// File: rtl/kf8253_seq_pkg.sv
// Shared types and constants for the KF8253 bus sequencer.
//   op_t        : request operation (PROGRAM / READ)
//   seq_state_t : main byte-sequencing FSM states
//   cyc_state_t : phases of one native-bus byte cycle
//   control_word: packs the 8253 control byte {counter, rw, mode, bcd}
package kf8253_seq_pkg;

  typedef enum logic {
    OP_PROGRAM = 1'b0,
    OP_READ    = 1'b1
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL,
    ST_LSB,
    ST_MSB,
    ST_RESP
  } seq_state_t;

  typedef enum logic [1:0] {
    CYC_SETUP,
    CYC_STROBE,
    CYC_HOLD,
    CYC_GAP
  } cyc_state_t;

  localparam logic [1:0] ADDR_CONTROL = 2'b11;
  localparam logic [1:0] LATCH_RW     = 2'b00;

  function automatic logic [7:0] control_word(input logic [1:0] counter,
                                              input logic [1:0] rw,
                                              input logic [2:0] mode,
                                              input logic       bcd);
    return {counter, rw, mode, bcd};
  endfunction

endpackage

// File: rtl/kf8253_bus_cycle.sv
// One native-bus byte cycle towards the KF8253: SETUP, STROBE, HOLD, GAP.
// Ports:
//   clock, reset            : system clock, asynchronous active-high reset
//   start                   : launch a cycle (accepted when idle or on done)
//   is_read, addr, wdata    : cycle direction, PIT address, write byte
//   busy                    : a cycle is in progress
//   done                    : high during the final clock of the cycle
//   rdata                   : byte sampled on the last STROBE clock of a read
//   pit_*                   : pin drivers; pit_data_in is the PIT read bus
module kf8253_bus_cycle
  import kf8253_seq_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       is_read,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       pit_chip_select_n,
  output logic       pit_read_enable_n,
  output logic       pit_write_enable_n,
  output logic [1:0] pit_address,
  output logic [7:0] pit_data_out,
  input  logic [7:0] pit_data_in
);

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST    = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  cyc_state_t state_q;
  logic       busy_q;
  logic [3:0] cnt_q;
  logic       is_read_q;
  logic [1:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;

  // The cycle ends after HOLD when there is no gap, otherwise after the last GAP clock.
  assign done = busy_q && (((state_q == CYC_HOLD) && (GAP_CYCLES == 0)) ||
                           ((state_q == CYC_GAP) && (cnt_q == GAP_LAST)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= CYC_SETUP;
      busy_q    <= 1'b0;
      cnt_q     <= 4'd0;
      is_read_q <= 1'b0;
      addr_q    <= 2'b00;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
    end else if (start && (!busy_q || done)) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= CYC_SETUP;
      busy_q    <= 1'b1;
      cnt_q     <= 4'd0;
      is_read_q <= is_read;
      addr_q    <= addr;
      wdata_q   <= wdata;
    end else if (busy_q) begin
      case (state_q)
        CYC_SETUP: begin
          state_q <= CYC_STROBE;
          cnt_q   <= 4'd0;
        end
        CYC_STROBE: begin
          if (cnt_q == STROBE_LAST) begin
            if (is_read_q) rdata_q <= pit_data_in;
            state_q <= CYC_HOLD;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        CYC_HOLD: begin
          if (GAP_CYCLES == 0) begin
            busy_q <= 1'b0;
          end else begin
            state_q <= CYC_GAP;
            cnt_q   <= 4'd0;
          end
        end
        CYC_GAP: begin
          if (cnt_q == GAP_LAST) busy_q <= 1'b0;
          else                   cnt_q  <= cnt_q + 4'd1;
        end
        default: busy_q <= 1'b0;
      endcase
    end
  end

  // Pins decode straight from registers, so reset releases them without waiting for a clock.
  assign busy               = busy_q;
  assign rdata              = rdata_q;
  assign pit_chip_select_n  = !(busy_q && (state_q != CYC_GAP));
  assign pit_read_enable_n  = !(busy_q && (state_q == CYC_STROBE) && is_read_q);
  assign pit_write_enable_n = !(busy_q && (state_q == CYC_STROBE) && !is_read_q);
  assign pit_address        = addr_q;
  assign pit_data_out       = wdata_q;

endmodule

// File: rtl/kf8253_bus_sequencer.sv
// Host-side sequencer that programs and reads back the KF8253 PIT over its
// native 8-bit bus. Accepts one request at a time (valid/ready), issues the
// control byte then LSB and/or MSB byte cycles, and returns a one-clock response.
// Optional build macro KF8253_SEQ_LATCH_EN: when defined, READ first writes the
// counter-latch control word; when undefined, READ goes straight to data reads.
// Ports:
//   clock, reset              : system clock, asynchronous active-high reset
//   req_*                     : request handshake and fields (captured on accept)
//   rsp_valid/rsp_data/rsp_error : one-clock completion, read data, reject flag
//   pit_*                     : KF8253 bus pins
module kf8253_bus_sequencer
  import kf8253_seq_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [1:0]  req_counter,
  input  logic [1:0]  req_rw,
  input  logic [2:0]  req_mode,
  input  logic        req_bcd,
  input  logic [15:0] req_count,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic        pit_chip_select_n,
  output logic        pit_read_enable_n,
  output logic        pit_write_enable_n,
  output logic [1:0]  pit_address,
  output logic [7:0]  pit_data_out,
  input  logic [7:0]  pit_data_in
);

  seq_state_t state_q, state_d, after_state, launch_state, first_state;
  op_t        op_q;
  logic [1:0] counter_q, rw_q, rw_in;
  logic [2:0] mode_q;
  logic       bcd_q, err_q;
  logic [15:0] count_q, data_q;

  logic       accept, cyc_start, cyc_read, cyc_busy, cyc_done;
  logic [1:0] cyc_addr;
  logic [7:0] cyc_wdata, cyc_rdata;

  assign req_ready = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign accept    = req_valid && req_ready;
  // A READ asking for no bytes reads both.
  assign rw_in     = (op_t'(req_op) == OP_READ && req_rw == 2'b00) ? 2'b11 : req_rw;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    first_state = ST_CTRL;
    if (req_counter != 2'd3 && op_t'(req_op) == OP_READ) begin
`ifdef KF8253_SEQ_LATCH_EN
      first_state = ST_CTRL;
`else
      first_state = rw_in[0] ? ST_LSB : ST_MSB;
`endif
    end
  end

  always_comb begin
    after_state = ST_RESP;
    case (state_q)
      ST_CTRL: after_state = rw_q[0] ? ST_LSB : (rw_q[1] ? ST_MSB : ST_RESP);
      ST_LSB:  after_state = rw_q[1] ? ST_MSB : ST_RESP;
      default: after_state = ST_RESP;
    endcase
  end

  // A byte state launches its own cycle when the bus is idle, and the next
  // byte's cycle on the done clock so consecutive cycles abut.
  always_comb begin
    state_d      = state_q;
    cyc_start    = 1'b0;
    launch_state = state_q;
    case (state_q)
      ST_IDLE, ST_RESP: state_d = accept ? first_state : ST_IDLE;
      ST_CTRL, ST_LSB, ST_MSB: begin
        if (err_q) begin
          state_d = ST_RESP;
        end else if (!cyc_busy) begin
          cyc_start = 1'b1;
        end else if (cyc_done) begin
          state_d      = after_state;
          launch_state = after_state;
          cyc_start    = (after_state != ST_RESP);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_read  = 1'b0;
    cyc_addr  = counter_q;
    cyc_wdata = 8'h00;
    case (launch_state)
      ST_CTRL: begin
        cyc_addr  = ADDR_CONTROL;
        cyc_wdata = (op_q == OP_READ) ? control_word(counter_q, LATCH_RW, 3'b000, 1'b0)
                                      : control_word(counter_q, rw_q, mode_q, bcd_q);
      end
      ST_LSB: begin
        cyc_read  = (op_q == OP_READ);
        cyc_wdata = cyc_read ? 8'h00 : count_q[7:0];
      end
      ST_MSB: begin
        cyc_read  = (op_q == OP_READ);
        cyc_wdata = cyc_read ? 8'h00 : count_q[15:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_PROGRAM;
      counter_q <= 2'b00;
      rw_q      <= 2'b00;
      mode_q    <= 3'b000;
      bcd_q     <= 1'b0;
      count_q   <= 16'h0000;
      err_q     <= 1'b0;
      data_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= op_t'(req_op);
        counter_q <= req_counter;
        rw_q      <= rw_in;
        mode_q    <= req_mode;
        bcd_q     <= req_bcd;
        count_q   <= req_count;
        err_q     <= (req_counter == 2'd3);
        data_q    <= 16'h0000;
      end else if (cyc_done && op_q == OP_READ) begin
        if (state_q == ST_LSB) data_q[7:0]  <= cyc_rdata;
        if (state_q == ST_MSB) data_q[15:8] <= cyc_rdata;
      end
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_valid ? data_q : 16'h0000;
  assign rsp_error = rsp_valid && err_q;

  kf8253_bus_cycle #(
    .STROBE_CYCLES(STROBE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_bus_cycle (
    .clock             (clock),
    .reset             (reset),
    .start             (cyc_start),
    .is_read           (cyc_read),
    .addr              (cyc_addr),
    .wdata             (cyc_wdata),
    .busy              (cyc_busy),
    .done              (cyc_done),
    .rdata             (cyc_rdata),
    .pit_chip_select_n (pit_chip_select_n),
    .pit_read_enable_n (pit_read_enable_n),
    .pit_write_enable_n(pit_write_enable_n),
    .pit_address       (pit_address),
    .pit_data_out      (pit_data_out),
    .pit_data_in       (pit_data_in)
  );

endmodule

// File: tb/tb_kf8253_bus_sequencer.sv
// Directed self-checking bench for kf8253_bus_sequencer (default parameters).
// A bus monitor logs each chip-select window as one byte-cycle record; the
// PIT read model returns 8'hCD for the first read after a test starts and 8'hAB after.
module tb_kf8253_bus_sequencer;

  localparam int S = 2;
  localparam int G = 1;
  localparam int BYTE_CLKS = S + 2 + G;
`ifdef KF8253_SEQ_LATCH_EN
  localparam int RD_BYTES_EXTRA = 1;
`else
  localparam int RD_BYTES_EXTRA = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [1:0]  req_counter = 2'b00;
  logic [1:0]  req_rw = 2'b00;
  logic [2:0]  req_mode = 3'b000;
  logic        req_bcd = 1'b0;
  logic [15:0] req_count = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_error;
  logic        pit_chip_select_n, pit_read_enable_n, pit_write_enable_n;
  logic [1:0]  pit_address;
  logic [7:0]  pit_data_out, pit_data_in;

  kf8253_bus_sequencer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_counter(req_counter), .req_rw(req_rw), .req_mode(req_mode),
    .req_bcd(req_bcd), .req_count(req_count),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .pit_chip_select_n(pit_chip_select_n), .pit_read_enable_n(pit_read_enable_n),
    .pit_write_enable_n(pit_write_enable_n), .pit_address(pit_address),
    .pit_data_out(pit_data_out), .pit_data_in(pit_data_in)
  );

  always #5 clock = ~clock;

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic wr, input logic [1:0] a, input logic [7:0] d,
                                       input int sl, input int cl);
    return {5'b0, wr, a, d, 8'(sl), 8'(cl)};
  endfunction

  // ---------------- cycle counter, PIT read model, bus monitor ----------------
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int rd_count = 0;
  int rd_base  = 0;
  assign pit_data_in = (rd_count == rd_base) ? 8'hCD : 8'hAB;

  logic [31:0] log_e [128];
  int   log_n = 0;
  int   cs_len = 0, wr_len = 0, rd_len = 0, hi_len = 0;
  int   min_gap = 1000, both_low = 0, outside = 0, rsp_count = 0;
  bit   seen = 1'b0;
  logic [1:0] cur_addr = 2'b00;
  logic [7:0] cur_data = 8'h00;

  always @(negedge clock) begin
    if (rsp_valid) rsp_count <= rsp_count + 1;
    if (!pit_chip_select_n) begin
      cs_len <= cs_len + 1;
      if (!pit_write_enable_n) begin
        wr_len <= wr_len + 1; cur_addr <= pit_address; cur_data <= pit_data_out;
      end
      if (!pit_read_enable_n) begin
        rd_len <= rd_len + 1; cur_addr <= pit_address; cur_data <= pit_data_out;
      end
      if (!pit_write_enable_n && !pit_read_enable_n) both_low <= both_low + 1;
      if (hi_len > 0) begin
        if (hi_len < min_gap) min_gap <= hi_len;
        hi_len <= 0;
      end
    end else begin
      if (!pit_write_enable_n || !pit_read_enable_n) outside <= outside + 1;
      if (cs_len > 0) begin
        if (log_n < 128) log_e[log_n] <= pack(wr_len > 0, cur_addr, cur_data, wr_len + rd_len, cs_len);
        log_n <= log_n + 1;
        if (rd_len > 0) rd_count <= rd_count + 1;
        cs_len <= 0; wr_len <= 0; rd_len <= 0; seen <= 1'b1;
      end
      if (seen || cs_len > 0) hi_len <= hi_len + 1;
    end
  end

  // ---------------- request driver ----------------
  logic [31:0] exp_q [$];
  int last_acc = 0, last_rsp = 0;

  // Called just after a negedge; returns just after the negedge where rsp_valid is seen.
  task automatic do_req(input string tag, input logic op, input logic [1:0] ctr, input logic [1:0] rw,
                        input logic [2:0] mode, input logic bcd, input logic [15:0] cnt,
                        output int lat, output logic [15:0] data, output logic err);
    int c0;
    bit got;
    req_valid = 1'b1; req_op = op; req_counter = ctr; req_rw = rw;
    req_mode = mode; req_bcd = bcd; req_count = cnt;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) break;
      @(negedge clock); #1;
    end
    c0 = cyc;
    @(posedge clock); #1;
    req_valid = 1'b0;
    // Scramble fields to show they were captured at acceptance.
    req_op = 1'($urandom); req_counter = 2'($urandom); req_rw = 2'($urandom);
    req_mode = 3'($urandom); req_bcd = 1'($urandom); req_count = 16'($urandom);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock); #1;
      if (rsp_valid) begin got = 1'b1; break; end
    end
    check({tag, " rsp_seen"}, 32'(got), 32'd1);
    lat = cyc - c0 - 1;
    data = rsp_data;
    err = rsp_error;
    last_acc = c0 + 1;
    last_rsp = cyc;
  endtask

  task automatic check_log(input string tag, input int base);
    check({tag, " n_cycles"}, 32'(log_n - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < log_n; i++)
      check($sformatf("%s byte%0d", tag, i), log_e[base + i], exp_q[i]);
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int lat, base, rc, acc1, rsp1;
    logic [15:0] d;
    logic e;
    bit reached;

    @(negedge clock); @(negedge clock); #1;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_data",  32'(rsp_data),  32'd0);
    check("rst rsp_error", 32'(rsp_error), 32'd0);
    check("rst pins", {26'b0, pit_chip_select_n, pit_read_enable_n, pit_write_enable_n, pit_address, 1'b0},
          {26'b0, 3'b111, 2'b00, 1'b0});
    check("rst data_out", 32'(pit_data_out), 32'd0);
    reset = 1'b0;
    @(negedge clock); #1;

    // PROGRAM counter0 mode3 rw=11 count 1234
    base = log_n;
    do_req("prog11", 1'b0, 2'd0, 2'b11, 3'd3, 1'b0, 16'h1234, lat, d, e);
    check("prog11 latency", 32'(lat), 32'(3 * BYTE_CLKS + 1));
    check("prog11 error", 32'(e), 32'd0);
    check("prog11 data", 32'(d), 32'd0);
    exp_q.push_back(pack(1'b1, 2'd3, 8'h36, S, S + 2));
    exp_q.push_back(pack(1'b1, 2'd0, 8'h34, S, S + 2));
    exp_q.push_back(pack(1'b1, 2'd0, 8'h12, S, S + 2));
    check_log("prog11", base);
    @(negedge clock); #1;
    check("prog11 rsp one clk", 32'(rsp_valid), 32'd0);

    // READ counter2 rw=11
    base = log_n; rd_base = rd_count;
    do_req("read11", 1'b1, 2'd2, 2'b11, 3'd0, 1'b0, 16'h0000, lat, d, e);
    check("read11 latency", 32'(lat), 32'((2 + RD_BYTES_EXTRA) * BYTE_CLKS + 1));
    check("read11 data", 32'(d), 32'hABCD);
    check("read11 error", 32'(e), 32'd0);
`ifdef KF8253_SEQ_LATCH_EN
    exp_q.push_back(pack(1'b1, 2'd3, 8'h80, S, S + 2));
`endif
    exp_q.push_back(pack(1'b0, 2'd2, 8'h00, S, S + 2));
    exp_q.push_back(pack(1'b0, 2'd2, 8'h00, S, S + 2));
    check_log("read11", base);

    // Illegal counter 3
    base = log_n;
    do_req("illegal", 1'b0, 2'd3, 2'b11, 3'd2, 1'b0, 16'h5555, lat, d, e);
    check("illegal latency", 32'(lat), 32'd1);
    check("illegal error", 32'(e), 32'd1);
    check("illegal data", 32'(d), 32'd0);
    check_log("illegal", base);

    // PROGRAM counter1 rw=01 mode2 bcd=1 count BEEF
    base = log_n;
    do_req("prog01", 1'b0, 2'd1, 2'b01, 3'd2, 1'b1, 16'hBEEF, lat, d, e);
    check("prog01 latency", 32'(lat), 32'(2 * BYTE_CLKS + 1));
    exp_q.push_back(pack(1'b1, 2'd3, 8'h55, S, S + 2));
    exp_q.push_back(pack(1'b1, 2'd1, 8'hEF, S, S + 2));
    check_log("prog01", base);

    // Back-to-back: PROGRAM rw=10 then READ counter1 rw=01
    base = log_n;
    do_req("b2b prog10", 1'b0, 2'd0, 2'b10, 3'd0, 1'b0, 16'hA55A, lat, d, e);
    check("b2b prog10 latency", 32'(lat), 32'(2 * BYTE_CLKS + 1));
    rsp1 = last_rsp;
    rd_base = rd_count;
    do_req("b2b read01", 1'b1, 2'd1, 2'b01, 3'd0, 1'b0, 16'h0000, lat, d, e);
    acc1 = last_acc;
    check("b2b accept after rsp", 32'(acc1 - rsp1), 32'd1);
    check("b2b read01 latency", 32'(lat), 32'((1 + RD_BYTES_EXTRA) * BYTE_CLKS + 1));
    check("b2b read01 data", 32'(d), 32'h00CD);
    exp_q.push_back(pack(1'b1, 2'd3, 8'h20, S, S + 2));
    exp_q.push_back(pack(1'b1, 2'd0, 8'hA5, S, S + 2));
`ifdef KF8253_SEQ_LATCH_EN
    exp_q.push_back(pack(1'b1, 2'd3, 8'h40, S, S + 2));
`endif
    exp_q.push_back(pack(1'b0, 2'd1, 8'h00, S, S + 2));
    check_log("b2b", base);

    // Reset during the MSB strobe of a PROGRAM rw=11
    @(negedge clock); #1;
    base = log_n;
    req_valid = 1'b1; req_op = 1'b0; req_counter = 2'd1; req_rw = 2'b11;
    req_mode = 3'd2; req_bcd = 1'b0; req_count = 16'h5678;
    @(posedge clock); #1;
    req_valid = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock); #1;
      if (log_n == base + 2 && !pit_write_enable_n) begin reached = 1'b1; break; end
    end
    check("abort reached msb strobe", 32'(reached), 32'd1);
    rc = rsp_count;
    #2 reset = 1'b1;
    #1;
    check("abort pins high", {29'b0, pit_chip_select_n, pit_read_enable_n, pit_write_enable_n}, 32'd7);
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    #1;
    check("abort no rsp", 32'(rsp_count), 32'(rc));
    check("abort req_ready", 32'(req_ready), 32'd1);
    check("abort cs idle", 32'(pit_chip_select_n), 32'd1);

    // READ counter0 rw=00 behaves as rw=11
    base = log_n; rd_base = rd_count;
    do_req("read00", 1'b1, 2'd0, 2'b00, 3'd0, 1'b0, 16'h0000, lat, d, e);
    check("read00 latency", 32'(lat), 32'((2 + RD_BYTES_EXTRA) * BYTE_CLKS + 1));
    check("read00 data", 32'(d), 32'hABCD);
`ifdef KF8253_SEQ_LATCH_EN
    exp_q.push_back(pack(1'b1, 2'd3, 8'h00, S, S + 2));
`endif
    exp_q.push_back(pack(1'b0, 2'd0, 8'h00, S, S + 2));
    exp_q.push_back(pack(1'b0, 2'd0, 8'h00, S, S + 2));
    check_log("read00", base);

    repeat (3) @(negedge clock);
    #1;
    check("one strobe at a time", 32'(both_low), 32'd0);
    check("strobe only under cs", 32'(outside), 32'd0);
    check("min cs_n high gap", 32'(min_gap), 32'(G));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
